// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-state data-memory responder.
// Holds the FSM state type, the default data width, the request address
// width used by the range check, response status constants and the
// address error check helper.
package dmem_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    // Width of the CPU byte address; bits above the word index are the
    // out-of-range mask.
    localparam int unsigned REQ_ADDR_W = 16;
    // Wait counter width covers WAIT_CYCLES 0..15.
    localparam int unsigned CNT_W      = 4;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    // Misaligned (bit 0 set) or any bit above the word index set.
    function automatic logic addr_bad(input logic [REQ_ADDR_W-1:0] addr,
                                      input int unsigned addr_w);
        logic bad;
        bad = addr[0];
        for (int unsigned i = 0; i < REQ_ADDR_W; i++) begin
            if (i > addr_w && addr[i]) begin
                bad = RESP_ERR;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM, no reset.
// Ports: clock, we (write enable), index (word index), wdata (write data),
// rdata (registered read of mem[index], read-before-write).
module dmem_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] index,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[index] <= wdata;
        end
        rdata <= mem[index];
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for the 16-bit MIPS core data port.
// Accepts one load/store at a time (req_valid/req_ready), waits WAIT_CYCLES,
// performs the access, and holds the response until resp_ready.
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake
//   req_write                 1 = store, 0 = load
//   req_addr, req_wdata       byte address, store data
//   resp_valid/resp_ready     response handshake
//   resp_rdata, resp_err      load data (0 for stores/errors), error flag
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [REQ_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic              lat_write, lat_err;
    logic [ADDR_W-1:0] lat_index;
    logic [DATA_W-1:0] lat_wdata;

    logic              req_err, accept, commit;
    logic              cur_write, cur_err;
    logic [ADDR_W-1:0] mem_index;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_we;

    assign req_err = addr_bad(req_addr, ADDR_W);
    assign accept  = (state == IDLE) && req_valid;
    // Access happens on the edge that enters RESP: last BUSY cycle, or the
    // accepting edge itself when there are no wait cycles.
    assign commit  = ((state == BUSY) && (cnt == CNT_W'(1)))
                   || (accept && (WAIT_CYCLES == 0));

    // In IDLE the RAM sees the live request so a zero-wait access can be
    // served on the accepting edge; otherwise it sees the latched request.
    always_comb begin
        mem_index = lat_index;
        mem_wdata = lat_wdata;
        cur_write = lat_write;
        cur_err   = lat_err;
        if (state == IDLE) begin
            mem_index = req_addr[ADDR_W:1];
            mem_wdata = req_wdata;
            cur_write = req_write;
            cur_err   = req_err;
        end
    end

    assign mem_we = reset_n && commit && cur_write && !cur_err;

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .index (mem_index),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counter and request latch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_err   <= RESP_OK;
            lat_index <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            cnt       <= WAIT_LD;
            lat_write <= req_write;
            lat_err   <= req_err;
            lat_index <= req_addr[ADDR_W:1];
            lat_wdata <= req_wdata;
        end else if (state == BUSY) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Next state
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (req_valid) state_next = (WAIT_CYCLES == 0) ? RESP : BUSY;
            BUSY: if (commit) state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = RESP_OK;
        resp_rdata = '0;
        unique case (state)
            IDLE: req_ready = 1'b1;
            BUSY: ;
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = lat_err;
                if (!lat_write && !lat_err) begin
                    resp_rdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;

    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [15:0] resp_rdata;

    logic        b_req_valid = 1'b0, b_req_write = 1'b0;
    logic        b_resp_ready = 1'b1;
    logic [15:0] b_req_addr = '0, b_req_wdata = '0;
    logic        b_req_ready, b_resp_valid, b_resp_err;
    logic [15:0] b_resp_rdata;

    int unsigned total = 0, passed = 0, failed = 0;

    // Reference model: word-addressed memory plus "has been written" flags.
    logic [15:0] ref_mem [1024];
    bit          known   [1024];
    logic [15:0] b_ref   [1024];

    always #5 clock = ~clock;

    dmem_responder #(.DATA_W(16), .ADDR_W(10), .WAIT_CYCLES(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DATA_W(16), .ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [15:0] addr);
        return (addr % 2 != 0) || (addr >= 16'd2048);
    endfunction

    // One transaction on the WAIT_CYCLES=2 instance; called at a negedge.
    task automatic txn(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                       input int unsigned hold,
                       output logic [15:0] rd, output logic er, output int unsigned lat);
        int unsigned guard;
        logic [15:0] pa;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0; req_write = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        check("resp_valid_timeout", resp_valid, 1);
        rd = resp_rdata;
        er = resp_err;
        // Backpressure window; the first cycle carries a stray store that
        // must be ignored.
        for (int unsigned i = 0; i < hold; i++) begin
            if (i == 0) begin
                pa = 16'($urandom_range(0, 31)) << 1;
                req_valid = 1'b1; req_write = 1'b1; req_addr = pa; req_wdata = 16'($urandom);
            end else begin
                req_valid = 1'b0; req_write = 1'b0;
            end
            @(negedge clock);
            check("hold_valid", resp_valid, 1);
            check("hold_rdata", resp_rdata, rd);
            check("hold_err", resp_err, er);
            check("hold_req_ready", req_ready, 0);
        end
        req_valid = 1'b0; req_write = 1'b0;
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        check("post_hs_valid", resp_valid, 0);
        check("post_hs_req_ready", req_ready, 1);
        check("post_hs_rdata", resp_rdata, 0);
        check("post_hs_err", resp_err, 0);
    endtask

    // Transaction with expectations taken from the reference model.
    task automatic run(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                       input int unsigned hold, input string tag);
        logic [15:0] rd;
        logic        er;
        int unsigned lat, idx;
        bit          e;
        e   = model_err(addr);
        idx = int'(addr / 2) % 1024;
        txn(wr, addr, wd, hold, rd, er, lat);
        check({tag, "_lat"}, lat, 3);
        check({tag, "_err"}, er, e);
        if (wr || e) check({tag, "_rdata"}, rd, 0);
        else if (known[idx]) check({tag, "_rdata"}, rd, ref_mem[idx]);
        if (wr && !e) begin
            ref_mem[idx] = wd;
            known[idx]   = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] a, d;
        logic        w;
        int unsigned kind;
        logic [15:0] b_addr [8];
        logic        b_wr   [8];
        logic [15:0] b_wd   [8];
        logic [15:0] expq [$];
        int unsigned k, nresp, last_resp, cyc;

        for (int i = 0; i < 1024; i++) known[i] = 1'b0;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed steps
        run(1'b1, 16'h0000, 16'h0005, 0, "st0");
        run(1'b0, 16'h0000, 16'h0000, 0, "ld0");
        check("ld0_known", ref_mem[0], 16'h0005);
        run(1'b1, 16'h0002, 16'h00AB, 0, "st2");
        run(1'b0, 16'h0002, 16'h0000, 0, "ld2");
        run(1'b0, 16'h0003, 16'h0000, 0, "ld_misaligned");
        run(1'b0, 16'h0800, 16'h0000, 0, "ld_range");
        run(1'b1, 16'h0801, 16'hFFFF, 0, "st_bad");
        run(1'b0, 16'h0002, 16'h0000, 0, "ld2_again");
        run(1'b0, 16'h0002, 16'h0000, 5, "ld2_backpressure");
        run(1'b0, 16'h0002, 16'h0000, 0, "ld2_after_stray");

        // Reset while a store is still waiting
        run(1'b1, 16'h0004, 16'h1111, 0, "st4_old");
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0004; req_wdata = 16'h1234;
        @(posedge clock);
        #1 req_valid = 1'b0; req_write = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("arst_req_ready", req_ready, 1);
        check("arst_resp_valid", resp_valid, 0);
        check("arst_rdata", resp_rdata, 0);
        check("arst_err", resp_err, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run(1'b0, 16'h0004, 16'h0000, 0, "ld4_after_rst");

        // Randomized: fill a small window, then mixed traffic
        for (int unsigned i = 0; i < 32; i++) run(1'b1, 16'(i * 2), 16'($urandom), 0, "fill");
        for (int unsigned i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7)       a = 16'($urandom_range(0, 31)) << 1;
            else if (kind == 7) a = (16'($urandom_range(0, 31)) << 1) | 16'h0001;
            else if (kind == 8) a = 16'h0800 | 16'($urandom_range(0, 2047));
            else                a = 16'($urandom);
            w = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            run(w, a, d, $urandom_range(0, 3), "rand");
        end

        // Zero-wait instance: back-to-back with resp_ready tied high
        for (int i = 0; i < 4; i++) begin
            b_addr[i] = 16'(16'h0010 + i * 2); b_wr[i] = 1'b1; b_wd[i] = 16'($urandom);
            b_addr[i + 4] = 16'(16'h0016 - i * 2); b_wr[i + 4] = 1'b0; b_wd[i + 4] = '0;
        end
        k = 0; nresp = 0; last_resp = 0; cyc = 0;
        while ((k < 8 || expq.size() != 0) && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (b_resp_valid) begin
                check("b_resp_expected", expq.size() != 0, 1);
                if (expq.size() != 0) check("b_rdata", b_resp_rdata, expq.pop_front());
                check("b_err", b_resp_err, 0);
                if (nresp > 0) check("b_period", cyc - last_resp, 2);
                last_resp = cyc;
                nresp++;
            end
            if (b_req_ready && k < 8) begin
                b_req_valid = 1'b1; b_req_write = b_wr[k];
                b_req_addr = b_addr[k]; b_req_wdata = b_wd[k];
                if (b_wr[k]) begin
                    b_ref[b_addr[k] / 2] = b_wd[k];
                    expq.push_back(16'h0000);
                end else begin
                    expq.push_back(b_ref[b_addr[k] / 2]);
                end
                k++;
            end else begin
                b_req_valid = 1'b0; b_req_write = 1'b0;
            end
        end
        check("b_all_responses", nresp, 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
